instr_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit processor. It fetches 8-bit instructions from program memory using a 5-bit program counter, decodes the 4-bit opcode, and drives single-cycle enable strobes to the R0/R1 register file, ACU/ALU and data memory. It sits between program memory and the datapath and replaces ad-hoc strobe generation in the processor top.

---
 rtl/instr_sequencer_if.sv | 34 +++
 rtl/instr_sequencer.sv | 106 ++++++++++
 tb/tb_instr_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> program memory / datapath bundle: fetch address and data, flags, and execute strobes.
// master = sequencer side, slave = memory/datapath side.
interface instr_sequencer_if #(
    parameter int PC_W = 5
);
    logic            run;
    logic [7:0]      prog_mem_data;
    logic            zero_flag;
    logic [PC_W-1:0] prog_cnt;
    logic [3:0]      instr_code;
    logic [3:0]      operand;
    logic            load_en;
    logic            store_en;
    logic            R0_ce;
    logic            R1_ce;
    logic            R0_oe;
    logic            R1_oe;
    logic            acu_ce;
    logic [1:0]      alu_op;
    logic            halted;
    logic            illegal;

    modport master (
        input  run, prog_mem_data, zero_flag,
        output prog_cnt, instr_code, operand, load_en, store_en,
               R0_ce, R1_ce, R0_oe, R1_oe, acu_ce, alu_op, halted, illegal
    );

    modport slave (
        output run, prog_mem_data, zero_flag,
        input  prog_cnt, instr_code, operand, load_en, store_en,
               R0_ce, R1_ce, R0_oe, R1_oe, acu_ce, alu_op, halted, illegal
    );
endinterface

// File: rtl/instr_sequencer.sv
// FETCH/DECODE/EXEC control unit: 3 cycles per instruction, strobes only in EXEC, PC moves on the EXEC edge.
// run=0 stalls in FETCH only; HLT parks in HALT until reset.
module instr_sequencer #(
    parameter int PC_W = 5
) (
    input  logic               clk,
    input  logic               rstn_ext,
    instr_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LD0 = 4'h1, OP_LD1 = 4'h2, OP_ADD = 4'h3,
                           OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_ST0 = 4'h7,
                           OP_ST1 = 4'h8, OP_STM = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
                           OP_HLT = 4'hF;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_opcode;
    logic [3:0]      r_operand;

    logic            w_load_en, w_store_en, w_r0_ce, w_r1_ce, w_r0_oe, w_r1_oe, w_acu_ce;
    logic [1:0]      w_alu_op;
    logic            w_illegal;
    logic            w_jump;
    logic [PC_W-1:0] w_target;

    always_ff @(posedge clk or negedge rstn_ext) begin
        if (!rstn_ext) r_state <= S_FETCH;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_en   = 1'b0;
        w_store_en  = 1'b0;
        w_r0_ce     = 1'b0;
        w_r1_ce     = 1'b0;
        w_r0_oe     = 1'b0;
        w_r1_oe     = 1'b0;
        w_acu_ce    = 1'b0;
        w_alu_op    = 2'b00;
        w_illegal   = 1'b0;
        w_jump      = 1'b0;
        case (r_state)
            S_FETCH:  if (bus.run) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_state_nxt = (r_opcode == OP_HLT) ? S_HALT : S_FETCH;
                case (r_opcode)
                    OP_LD0: begin w_load_en = 1'b1; w_r0_ce = 1'b1; end
                    OP_LD1: begin w_load_en = 1'b1; w_r1_ce = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        w_r0_oe  = 1'b1;
                        w_r1_oe  = 1'b1;
                        w_acu_ce = 1'b1;
                        // ALU ops are consecutive opcodes starting at ADD
                        w_alu_op = 2'(r_opcode - OP_ADD);
                    end
                    OP_ST0: w_r0_ce    = 1'b1;
                    OP_ST1: w_r1_ce    = 1'b1;
                    OP_STM: w_store_en = 1'b1;
                    OP_JMP: w_jump     = 1'b1;
                    OP_JZ:  w_jump     = bus.zero_flag;
                    OP_NOP, OP_HLT: ;
                    default: w_illegal = 1'b1;
                endcase
            end
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    assign w_target = {{(PC_W-4){1'b0}}, r_operand};

    always_ff @(posedge clk or negedge rstn_ext) begin
        if (!rstn_ext) begin
            r_pc      <= '0;
            r_opcode  <= 4'h0;
            r_operand <= 4'h0;
        end else begin
            if (r_state == S_DECODE) {r_opcode, r_operand} <= bus.prog_mem_data;
            if (r_state == S_EXEC)   r_pc <= w_jump ? w_target : r_pc + 1'b1;
        end
    end

    assign bus.prog_cnt   = r_pc;
    assign bus.instr_code = r_opcode;
    assign bus.operand    = r_operand;
    assign bus.load_en    = w_load_en;
    assign bus.store_en   = w_store_en;
    assign bus.R0_ce      = w_r0_ce;
    assign bus.R1_ce      = w_r1_ce;
    assign bus.R0_oe      = w_r0_oe;
    assign bus.R1_oe      = w_r1_oe;
    assign bus.acu_ce     = w_acu_ce;
    assign bus.alu_op     = w_alu_op;
    assign bus.illegal    = w_illegal;
    assign bus.halted     = (r_state == S_HALT);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: runs a small program from a synchronous-read memory
// model and checks strobes, PC flow, stall, async reset and HALT against hand-computed values.
module tb_instr_sequencer;
    localparam int PC_W = 5;

    // Strobe vector: {load, store, R0_ce, R1_ce, R0_oe, R1_oe, acu_ce, alu_op[1:0], illegal}
    localparam logic [9:0] S_NONE = 10'b0_0_0_0_0_0_0_00_0;
    localparam logic [9:0] S_LD0  = 10'b1_0_1_0_0_0_0_00_0;
    localparam logic [9:0] S_LD1  = 10'b1_0_0_1_0_0_0_00_0;
    localparam logic [9:0] S_ADD  = 10'b0_0_0_0_1_1_1_00_0;
    localparam logic [9:0] S_ILL  = 10'b0_0_0_0_0_0_0_00_1;

    logic       clk = 1'b0;
    logic       rstn_ext;
    logic [7:0] mem [0:31];
    logic [9:0] strb;
    int         n_chk  = 0;
    int         n_pass = 0;

    instr_sequencer_if #(.PC_W(PC_W)) bus ();

    instr_sequencer #(.PC_W(PC_W)) dut (
        .clk      (clk),
        .rstn_ext (rstn_ext),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.prog_mem_data <= mem[bus.prog_cnt];

    assign strb = {bus.load_en, bus.store_en, bus.R0_ce, bus.R1_ce, bus.R0_oe,
                   bus.R1_oe, bus.acu_ce, bus.alu_op, bus.illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a FETCH-cycle negedge; leaves at the next FETCH-cycle negedge.
    task automatic exec_check(input string tag, input logic [7:0] instr,
                              input logic [9:0] exp_strb, input logic run_after);
        chk({tag, "_fetch_strb"}, strb, S_NONE);
        step();
        chk({tag, "_decode_strb"}, strb, S_NONE);
        step();
        chk({tag, "_exec_strb"}, strb, exp_strb);
        chk({tag, "_instr"}, {bus.instr_code, bus.operand}, instr);
        chk({tag, "_halted"}, bus.halted, 1'b0);
        bus.run = run_after;
        step();
    endtask

    initial begin
        int bad;
        rstn_ext      = 1'b0;
        bus.run       = 1'b1;
        bus.zero_flag = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h15;  // LD0 5
        mem[1]  = 8'h23;  // LD1 3
        mem[2]  = 8'h30;  // ADD
        mem[3]  = 8'hB7;  // JZ 7
        mem[7]  = 8'hB9;  // JZ 9
        mem[8]  = 8'hAC;  // JMP 12
        mem[12] = 8'hD0;  // undefined
        mem[13] = 8'hAF;  // JMP 15

        repeat (3) @(negedge clk);
        chk("rst_pc", bus.prog_cnt, 0);
        chk("rst_strb", strb, S_NONE);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_instr", {bus.instr_code, bus.operand}, 8'h00);

        rstn_ext = 1'b1;
        exec_check("ld0", 8'h15, S_LD0, 1'b1);
        exec_check("ld1", 8'h23, S_LD1, 1'b1);
        exec_check("add", 8'h30, S_ADD, 1'b1);
        chk("pc_after_add", bus.prog_cnt, 3);

        bus.zero_flag = 1'b1;
        exec_check("jz_taken", 8'hB7, S_NONE, 1'b1);
        chk("pc_jz_taken", bus.prog_cnt, 7);
        bus.zero_flag = 1'b0;
        exec_check("jz_not", 8'hB9, S_NONE, 1'b1);
        chk("pc_jz_not", bus.prog_cnt, 8);
        exec_check("jmp", 8'hAC, S_NONE, 1'b1);
        chk("pc_jmp", bus.prog_cnt, 12);
        exec_check("illegal", 8'hD0, S_ILL, 1'b1);
        chk("pc_illegal", bus.prog_cnt, 13);
        exec_check("jmp15", 8'hAF, S_NONE, 1'b1);

        for (int a = 15; a < 32; a++) begin
            chk("pc_seq", bus.prog_cnt, a);
            exec_check("nop", 8'h00, S_NONE, (a == 31) ? 1'b0 : 1'b1);
        end
        chk("pc_wrap", bus.prog_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc", bus.prog_cnt, 0);
            chk("stall_strb", strb, S_NONE);
        end
        mem[1]  = 8'h94;  // STM 4
        bus.run = 1'b1;
        exec_check("ld0_resume", 8'h15, S_LD0, 1'b1);
        chk("pc_resume", bus.prog_cnt, 1);

        step();  // now in DECODE of STM
        rstn_ext = 1'b0;
        #1;
        chk("arst_strb", strb, S_NONE);
        chk("arst_pc", bus.prog_cnt, 0);
        chk("arst_instr", {bus.instr_code, bus.operand}, 8'h00);
        chk("arst_halted", bus.halted, 1'b0);
        mem[0] = 8'hF0;  // HLT
        for (int i = 0; i < 2; i++) begin
            step();
            chk("arst_store_en", bus.store_en, 1'b0);
        end
        rstn_ext = 1'b1;
        chk("restart_pc", bus.prog_cnt, 0);
        exec_check("hlt", 8'hF0, S_NONE, 1'b1);
        chk("halted", bus.halted, 1'b1);
        chk("halt_pc", bus.prog_cnt, 1);

        bad = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.halted !== 1'b1 || bus.prog_cnt !== 5'd1 || strb !== S_NONE) bad++;
        end
        chk("halt_hold_bad_cycles", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
